uart_receiver: RTL

Serial-to-parallel UART receiver, 8N1 at a fixed baud rate. It sits directly downstream of the board transmitter and consumes its TxD line, typically in a loopback or second-board setup. It oversamples the line, recovers each byte, and presents it on a parallel bus with a one-cycle valid strobe for LEDs or a downstream consumer.

---
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined), oversampled majority-vote bit recovery.
// Bytes appear on data with a one-cycle data_valid strobe; framing and parity errors pulse for one cycle.
module uart_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SAMP_A    = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] SAMP_B    = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] DECIDE    = TICK_W'(OVERSAMPLE / 2 + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t state_reg, state_next;

  logic              rx_meta_reg, rxs_reg, rxs_prev_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [1:0]        samp_reg;
  logic [2:0]        bit_idx_reg;
  logic [7:0]        shift_reg;
  logic [7:0]        data_reg;
  logic              data_valid_reg, framing_err_reg, busy_reg;
  logic              data_valid_next, framing_err_next, busy_next;
  logic              tick, decide, maj;
`ifdef UART_RX_PARITY_EN
  logic              parity_bad_reg, parity_err_reg, parity_err_next;
`endif

  assign tick   = (state_reg != S_IDLE) && (div_cnt_reg == DIV_LAST);
  assign decide = tick && (tick_cnt_reg == DECIDE);
  // Third vote is the live sample taken at the decision tick itself.
  assign maj    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs_reg) | (samp_reg[1] & rxs_reg);

  always_comb begin
    state_next       = state_reg;
    data_valid_next  = 1'b0;
    framing_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_next  = 1'b0;
`endif
    case (state_reg)
      S_IDLE:  if (rxs_prev_reg && !rxs_reg) state_next = S_START;
      S_START: if (decide) state_next = maj ? S_IDLE : S_DATA;
      S_DATA: begin
        if (decide && bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (decide) state_next = S_STOP;
`endif
      S_STOP: begin
        if (decide) begin
          if (!maj) begin
            framing_err_next = 1'b1;
            state_next       = S_BREAK;
          end else begin
            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_reg) parity_err_next = 1'b1;
            else                data_valid_next = 1'b1;
`else
            data_valid_next = 1'b1;
`endif
          end
        end
      end
      S_BREAK: if (rxs_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef UART_RX_PARITY_EN
    busy_next = (state_next == S_DATA) || (state_next == S_PARITY) || (state_next == S_STOP);
`else
    busy_next = (state_next == S_DATA) || (state_next == S_STOP);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      rx_meta_reg     <= 1'b1;
      rxs_reg         <= 1'b1;
      rxs_prev_reg    <= 1'b1;
      div_cnt_reg     <= '0;
      tick_cnt_reg    <= '0;
      samp_reg        <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      data_valid_reg  <= 1'b0;
      framing_err_reg <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_reg  <= 1'b0;
      parity_err_reg  <= 1'b0;
`endif
    end else begin
      rx_meta_reg     <= RxD;
      rxs_reg         <= rx_meta_reg;
      rxs_prev_reg    <= rxs_reg;
      state_reg       <= state_next;
      data_valid_reg  <= data_valid_next;
      framing_err_reg <= framing_err_next;
      busy_reg        <= busy_next;
`ifdef UART_RX_PARITY_EN
      parity_err_reg  <= parity_err_next;
`endif
      // Bit timing restarts from the start edge so every decision lands mid-bit.
      if (state_reg == S_IDLE && state_next == S_START) begin
        div_cnt_reg  <= '0;
        tick_cnt_reg <= '0;
      end else if (state_reg != S_IDLE) begin
        div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
        if (tick) begin
          tick_cnt_reg <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + TICK_W'(1);
          if (tick_cnt_reg == SAMP_A) samp_reg[0] <= rxs_reg;
          if (tick_cnt_reg == SAMP_B) samp_reg[1] <= rxs_reg;
        end
      end
      if (decide && state_reg == S_START) bit_idx_reg <= '0;
      if (decide && state_reg == S_DATA) begin
        shift_reg   <= {maj, shift_reg[7:1]};
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (decide && state_reg == S_PARITY) parity_bad_reg <= (^shift_reg) ^ maj;
`endif
      if (data_valid_next) data_reg <= shift_reg;
    end
  end

  assign data        = data_reg;
  assign data_valid  = data_valid_reg;
  assign framing_err = framing_err_reg;
  assign busy        = busy_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_reg;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
